mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/bus_pkg.sv | 13 +
 rtl/mem_bus_arbiter_if.sv | 45 ++++
 rtl/rr_pick.sv | 26 ++
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared constants for the memory bus arbiter: IO window code and FSM state encoding.
package bus_pkg;

  localparam logic [1:0] IO_WINDOW = 2'b11;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  function automatic logic in_io_window(input logic [1:0] top_bits);
    return top_bits == IO_WINDOW;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the arbiter's master-side and memory-side bus signals (clock/reset excluded).
// Handshake: a port holds req_in with stable addr/wr/wdata; grant_out high means the byte
// access happened this cycle; rvalid_out qualifies rdata_out one cycle after a granted read.
interface mem_bus_arbiter_if #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17
);
  logic [NUM_PORTS-1:0]            req_in;
  logic [NUM_PORTS-1:0]            lock_in;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_in;
  logic [NUM_PORTS-1:0]            wr_in;
  logic [NUM_PORTS*8-1:0]          wdata_in;
  logic [NUM_PORTS-1:0]            grant_out;
  logic [NUM_PORTS-1:0]            rvalid_out;
  logic [7:0]                      rdata_out;
  logic                            dbg_active_in;
  logic [RAM_ADDR_WIDTH-1:0]       dbg_addr_in;
  logic                            dbg_wr_in;
  logic [7:0]                      dbg_wdata_in;
  logic [ADDR_WIDTH-1:0]           mem_a_out;
  logic                            mem_wr_out;
  logic [7:0]                      mem_dout_out;
  logic                            ram_en_out;
  logic                            io_en_out;
  logic [7:0]                      ram_din_in;
  logic [7:0]                      io_din_in;
  logic                            io_full_in;

  modport master (
    output req_in, lock_in, addr_in, wr_in, wdata_in,
    output dbg_active_in, dbg_addr_in, dbg_wr_in, dbg_wdata_in,
    output ram_din_in, io_din_in, io_full_in,
    input  grant_out, rvalid_out, rdata_out,
    input  mem_a_out, mem_wr_out, mem_dout_out, ram_en_out, io_en_out
  );

  modport slave (
    input  req_in, lock_in, addr_in, wr_in, wdata_in,
    input  dbg_active_in, dbg_addr_in, dbg_wr_in, dbg_wdata_in,
    input  ram_din_in, io_din_in, io_full_in,
    output grant_out, rvalid_out, rdata_out,
    output mem_a_out, mem_wr_out, mem_dout_out, ram_en_out, io_en_out
  );
endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: one-hot of the first set request found after position 'last'.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick
);

  always_comb begin
    int  idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Byte-wide round-robin memory bus arbiter with lockable bursts, IO backpressure,
// debug-master override and one-cycle-latency read return steering.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [NUM_PORTS-1:0]            req_in,
  input  logic [NUM_PORTS-1:0]            lock_in,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_in,
  input  logic [NUM_PORTS-1:0]            wr_in,
  input  logic [NUM_PORTS*8-1:0]          wdata_in,
  output logic [NUM_PORTS-1:0]            grant_out,
  output logic [NUM_PORTS-1:0]            rvalid_out,
  output logic [7:0]                      rdata_out,
  input  logic                            dbg_active_in,
  input  logic [RAM_ADDR_WIDTH-1:0]       dbg_addr_in,
  input  logic                            dbg_wr_in,
  input  logic [7:0]                      dbg_wdata_in,
  output logic [ADDR_WIDTH-1:0]           mem_a_out,
  output logic                            mem_wr_out,
  output logic [7:0]                      mem_dout_out,
  output logic                            ram_en_out,
  output logic                            io_en_out,
  input  logic [7:0]                      ram_din_in,
  input  logic [7:0]                      io_din_in,
  input  logic                            io_full_in
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [0:0]           state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        last_q, last_d;
  logic                 rsel_io_q, rsel_io_d;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;

  logic [ADDR_WIDTH-1:0] port_addr [NUM_PORTS];
  logic [NUM_PORTS-1:0]  eligible, rr_grant, grant;
  logic [IW-1:0]         gidx;
  logic                  hold, any_grant, bus_active;

  // A write into the IO window cannot proceed while the IO buffer is full.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_addr[i] = addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
      eligible[i]  = req_in[i] &&
                     !(wr_in[i] && io_full_in &&
                       in_io_window(port_addr[i][RAM_ADDR_WIDTH -: 2]));
    end
  end

  rr_pick #(.N(NUM_PORTS), .IW(IW)) u_rr_pick (
    .req  (eligible),
    .last (last_q),
    .pick (rr_grant)
  );

  // The lock is released in the same cycle the owner drops lock or request.
  always_comb begin
    hold  = (state_q == ST_LOCKED) && req_in[owner_q] && lock_in[owner_q];
    grant = '0;
    if (rst_n_in && !dbg_active_in) begin
      if (hold) grant[owner_q] = eligible[owner_q];
      else      grant          = rr_grant;
    end
    gidx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) gidx = IW'(i);
    end
    any_grant = |grant;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (!dbg_active_in) begin
      state_d = hold ? ST_LOCKED : ST_IDLE;
      if (any_grant) begin
        last_d = gidx;
        if (lock_in[gidx]) begin
          state_d = ST_LOCKED;
          owner_d = gidx;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_comb begin
    mem_a_out    = '0;
    mem_wr_out   = 1'b0;
    mem_dout_out = '0;
    if (rst_n_in) begin
      if (dbg_active_in) begin
        mem_a_out    = ADDR_WIDTH'(dbg_addr_in);
        mem_wr_out   = dbg_wr_in;
        mem_dout_out = dbg_wdata_in;
      end else if (any_grant) begin
        mem_a_out    = port_addr[gidx];
        mem_wr_out   = wr_in[gidx];
        mem_dout_out = wdata_in[int'(gidx)*8 +: 8];
      end
    end
    bus_active = rst_n_in && (dbg_active_in || any_grant);
    io_en_out  = bus_active && in_io_window(mem_a_out[RAM_ADDR_WIDTH -: 2]);
    ram_en_out = bus_active && !in_io_window(mem_a_out[RAM_ADDR_WIDTH -: 2]);
    rsel_io_d  = io_en_out;
    rvalid_d   = grant & ~wr_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      last_q    <= IW'(NUM_PORTS - 1);
      rsel_io_q <= 1'b0;
      rvalid_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      rsel_io_q <= rsel_io_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign grant_out  = grant;
  assign rvalid_out = rvalid_q;
  assign rdata_out  = rsel_io_q ? io_din_in : ram_din_in;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by random traffic, all checked
// against a cycle-level reference model of the arbitration rules.
module tb_mem_bus_arbiter;

  localparam int NP  = 2;
  localparam int AW  = 32;
  localparam int RAW = 17;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;

  mem_bus_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RAW)) bus_if ();

  mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RAW)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .req_in        (bus_if.req_in),
    .lock_in       (bus_if.lock_in),
    .addr_in       (bus_if.addr_in),
    .wr_in         (bus_if.wr_in),
    .wdata_in      (bus_if.wdata_in),
    .grant_out     (bus_if.grant_out),
    .rvalid_out    (bus_if.rvalid_out),
    .rdata_out     (bus_if.rdata_out),
    .dbg_active_in (bus_if.dbg_active_in),
    .dbg_addr_in   (bus_if.dbg_addr_in),
    .dbg_wr_in     (bus_if.dbg_wr_in),
    .dbg_wdata_in  (bus_if.dbg_wdata_in),
    .mem_a_out     (bus_if.mem_a_out),
    .mem_wr_out    (bus_if.mem_wr_out),
    .mem_dout_out  (bus_if.mem_dout_out),
    .ram_en_out    (bus_if.ram_en_out),
    .io_en_out     (bus_if.io_en_out),
    .ram_din_in    (bus_if.ram_din_in),
    .io_din_in     (bus_if.io_din_in),
    .io_full_in    (bus_if.io_full_in)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- memory models (1-cycle read latency) ----------------
  function automatic logic [7:0] ram_fn(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] io_fn(input logic [AW-1:0] a);
    return ~a[7:0];
  endfunction

  function automatic bit io_win(input logic [AW-1:0] a);
    return ((a >> (RAW - 1)) & 3) == 3;
  endfunction

  initial begin
    bus_if.ram_din_in = 8'h00;
    bus_if.io_din_in  = 8'h00;
  end

  always @(posedge clk_in) begin
    bus_if.ram_din_in <= bus_if.ram_en_out ? ram_fn(bus_if.mem_a_out) : 8'h00;
    bus_if.io_din_in  <= bus_if.io_en_out  ? io_fn(bus_if.mem_a_out)  : 8'h00;
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- reference model state ----------------
  int             m_last   = NP - 1;
  bit             m_locked = 1'b0;
  int             m_owner  = 0;
  logic [NP-1:0]  m_rvalid = '0;
  logic [7:0]     m_rdata  = 8'h00;
  logic [7:0]     exp_rd_q[$];

  logic [NP-1:0]  obs_grant;
  logic [NP-1:0]  obs_rvalid;
  logic [7:0]     obs_rdata;
  logic [AW-1:0]  obs_mem_a;
  logic           obs_io_en;
  logic           obs_mem_wr;

  function automatic logic [AW-1:0] paddr(input int p);
    return bus_if.addr_in[p*AW +: AW];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input logic req, input logic lock, input logic wr,
                          input logic [AW-1:0] addr, input logic [7:0] wdata);
    bus_if.req_in[p]             = req;
    bus_if.lock_in[p]            = lock;
    bus_if.wr_in[p]              = wr;
    bus_if.addr_in[p*AW +: AW]   = addr;
    bus_if.wdata_in[p*8 +: 8]    = wdata;
  endtask

  task automatic set_dbg(input logic act, input logic [RAW-1:0] a, input logic wr,
                         input logic [7:0] d);
    bus_if.dbg_active_in = act;
    bus_if.dbg_addr_in   = a;
    bus_if.dbg_wr_in     = wr;
    bus_if.dbg_wdata_in  = d;
  endtask

  // Called just after a falling edge with inputs already applied; checks one bus cycle.
  task automatic step();
    logic [NP-1:0] elig, eg;
    logic [AW-1:0] exp_a;
    logic          exp_wr;
    logic [7:0]    exp_dout;
    logic          exp_act, exp_io;
    int            g;
    bit            holding;
    #1;
    for (int p = 0; p < NP; p++)
      elig[p] = bus_if.req_in[p] &&
                !(bus_if.wr_in[p] && bus_if.io_full_in && io_win(paddr(p)));
    g  = -1;
    eg = '0;
    holding = m_locked && bus_if.req_in[m_owner] && bus_if.lock_in[m_owner];
    if (!bus_if.dbg_active_in) begin
      if (holding) begin
        if (elig[m_owner]) g = m_owner;
      end else begin
        for (int k = 1; k <= NP; k++) begin
          int p;
          p = (m_last + k) % NP;
          if (g < 0 && elig[p]) g = p;
        end
      end
    end
    if (g >= 0) eg[g] = 1'b1;

    exp_a = '0; exp_wr = 1'b0; exp_dout = 8'h00;
    if (bus_if.dbg_active_in) begin
      exp_a    = {{(AW-RAW){1'b0}}, bus_if.dbg_addr_in};
      exp_wr   = bus_if.dbg_wr_in;
      exp_dout = bus_if.dbg_wdata_in;
    end else if (g >= 0) begin
      exp_a    = paddr(g);
      exp_wr   = bus_if.wr_in[g];
      exp_dout = bus_if.wdata_in[g*8 +: 8];
    end
    exp_act = bus_if.dbg_active_in || (g >= 0);
    exp_io  = exp_act && io_win(exp_a);

    obs_grant  = bus_if.grant_out;
    obs_rvalid = bus_if.rvalid_out;
    obs_rdata  = bus_if.rdata_out;
    obs_mem_a  = bus_if.mem_a_out;
    obs_io_en  = bus_if.io_en_out;
    obs_mem_wr = bus_if.mem_wr_out;

    chk("grant",  bus_if.grant_out, eg);
    chk("rvalid", bus_if.rvalid_out, m_rvalid);
    if (m_rvalid != '0) chk("rdata", bus_if.rdata_out, exp_rd_q.pop_front());
    chk("mem_a",    bus_if.mem_a_out, exp_a);
    chk("mem_wr",   bus_if.mem_wr_out, exp_wr);
    chk("mem_dout", bus_if.mem_dout_out, exp_dout);
    chk("en", {bus_if.ram_en_out, bus_if.io_en_out}, {exp_act && !exp_io, exp_io});

    if (!bus_if.dbg_active_in) begin
      if (g >= 0) begin
        m_last   = g;
        m_locked = bus_if.lock_in[g];
        if (bus_if.lock_in[g]) m_owner = g;
      end else if (!holding) begin
        m_locked = 1'b0;
      end
    end
    m_rvalid = '0;
    if (g >= 0 && !bus_if.wr_in[g]) begin
      m_rvalid[g] = 1'b1;
      exp_rd_q.push_back(io_win(paddr(g)) ? io_fn(paddr(g)) : ram_fn(paddr(g)));
    end
    @(negedge clk_in);
  endtask

  // Asserts reset at a falling edge, checks everything is quiet, releases after two cycles.
  task automatic do_reset(input string tag);
    rst_n_in = 1'b0;
    #1;
    chk({tag, "_grant"},  bus_if.grant_out, '0);
    chk({tag, "_rvalid"}, bus_if.rvalid_out, '0);
    chk({tag, "_mem_a"},  bus_if.mem_a_out, '0);
    chk({tag, "_mem_wr"}, bus_if.mem_wr_out, 1'b0);
    chk({tag, "_en"},     {bus_if.ram_en_out, bus_if.io_en_out}, 2'b00);
    m_last   = NP - 1;
    m_locked = 1'b0;
    m_rvalid = '0;
    exp_rd_q.delete();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int p = 0; p < NP; p++) set_port(p, 0, 0, 0, '0, 8'h00);
    set_dbg(0, '0, 0, 8'h00);
    bus_if.io_full_in = 1'b0;
    set_port(0, 1, 0, 0, 32'h100, 8'h00);
    set_port(1, 1, 0, 0, 32'h200, 8'h00);
    @(negedge clk_in);
    do_reset("reset");

    // Continuous reads from both ports alternate, starting with port 0.
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_alt_grant", obs_grant, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) chk("rr_alt_rdata", obs_rdata, (i % 2 == 1) ? ram_fn(32'h100) : ram_fn(32'h200));
    end

    // Port 1 locks for four reads while port 0 keeps requesting.
    set_port(1, 0, 0, 0, 32'h200, 8'h00);
    step();
    chk("lock_pre", obs_grant, 2'b01);
    set_port(1, 1, 1, 0, 32'h240, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lock_burst", obs_grant, 2'b10);
    end
    set_port(1, 0, 0, 0, 32'h240, 8'h00);
    step();
    chk("lock_after", obs_grant, 2'b01);

    // IO write blocked by full buffer; RAM reader proceeds.
    bus_if.io_full_in = 1'b1;
    set_port(0, 1, 0, 1, 32'h30000, 8'hA5);
    set_port(1, 1, 0, 0, 32'h10, 8'h00);
    step();
    chk("iofull_other", obs_grant, 2'b10);
    set_port(1, 0, 0, 0, 32'h10, 8'h00);
    step();
    chk("iofull_stall", obs_grant, 2'b00);
    bus_if.io_full_in = 1'b0;
    step();
    chk("iofull_go", obs_grant, 2'b01);
    chk("iofull_io_en", obs_io_en, 1'b1);
    chk("iofull_wr", obs_mem_wr, 1'b1);

    // Back-to-back IO read then RAM read: rdata steering follows the access type.
    set_port(0, 1, 0, 0, 32'h30004, 8'h00);
    step();
    set_port(0, 1, 0, 0, 32'h00004, 8'h00);
    step();
    chk("steer_io_valid", obs_rvalid, 2'b01);
    chk("steer_io_data", obs_rdata, 8'hFB);
    set_port(0, 0, 0, 0, 32'h0, 8'h00);
    step();
    chk("steer_ram_valid", obs_rvalid, 2'b01);
    chk("steer_ram_data", obs_rdata, 8'h5E);

    // Debug master interrupts a locked burst of port 0.
    set_port(0, 1, 1, 0, 32'h40, 8'h00);
    step();
    chk("dbg_pre", obs_grant, 2'b01);
    set_port(1, 1, 0, 0, 32'h80, 8'h00);
    set_dbg(1, 17'h1ABCD, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dbg_grant", obs_grant, 2'b00);
      chk("dbg_addr", obs_mem_a, 32'h0001ABCD);
    end
    set_dbg(0, '0, 0, 8'h00);
    step();
    chk("dbg_resume", obs_grant, 2'b01);

    // Reset mid-burst clears ownership and any pending read return.
    step();
    do_reset("midreset");
    set_port(0, 1, 0, 0, 32'h44, 8'h00);
    step();
    chk("post_reset_first", obs_grant, 2'b01);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        logic [AW-1:0] a;
        a = ($urandom_range(0, 2) == 0) ? (32'h30000 | AW'($urandom_range(0, 255)))
                                        : AW'($urandom_range(0, 32'h2FFFF));
        set_port(p, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 1) == 1, a, 8'($urandom_range(0, 255)));
      end
      bus_if.io_full_in = ($urandom_range(0, 2) == 0);
      set_dbg($urandom_range(0, 9) == 0, RAW'($urandom_range(0, 32'h1FFFF)),
              $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
